// File: rtl/jk_sync_counter_pkg.sv
// Shared constants for the JK-stage counter: per-stage J/K modes and count direction.
package counter_pkg;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_CLEAR  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;
endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of jk_sync_counter; master drives controls, slave is the counter.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_n;
  logic             terminal_count;

  modport master (
    output enable, up_down, load, load_value,
    input  count, count_n, terminal_count
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output count, count_n, terminal_count
  );
endinterface

// File: rtl/jk_sync_counter_stage.sv
// Single positive-edge JK flip-flop with asynchronous active-low clear.
module jk_stage
  import counter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qnot
);
  logic r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD:  r_q <= r_q;
        JK_CLEAR: r_q <= 1'b0;
        JK_SET:   r_q <= 1'b1;
        default:  r_q <= ~r_q;
      endcase
    end
  end

  assign Q    = r_q;
  assign Qnot = ~r_q;
endmodule

// File: rtl/jk_sync_counter.sv
// Loadable up/down counter built from WIDTH JK stages with a cascade strobe.
// Define COUNTER_MODULO_EN to count 0..MODULUS-1 instead of wrapping over 2^WIDTH.
module jk_sync_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic           clock,
  input  logic           reset_n,
  jk_sync_counter_if.slave bus
);
  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
    $error("jk_sync_counter: WIDTH or MODULUS out of range");
  end

`ifdef COUNTER_MODULO_EN
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] MAXV = '1;
`endif

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_zeros;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_ldv;
  logic             w_ld;
  logic             w_up;
  logic             w_tc;
  logic [1:0]       w_jk [WIDTH];

  assign w_up = (bus.up_down == DIR_UP);
  assign w_tc = bus.enable & ~bus.load &
                ((w_up & (w_q == MAXV)) | ((bus.up_down == DIR_DOWN) & (w_q == '0)));

`ifdef COUNTER_MODULO_EN
  // Both wraps reuse the load path: the terminal condition forces 0 or MAXV in.
  assign w_ld  = bus.load | w_tc;
  assign w_ldv = bus.load ? (({1'b0, bus.load_value} >= (WIDTH+1)'(MODULUS)) ? MAXV : bus.load_value)
                          : (w_up ? '0 : MAXV);
`else
  assign w_ld  = bus.load;
  assign w_ldv = bus.load_value;
`endif

  // AND ladders: stage i toggles once all lower stages are ones (up) or zeros (down).
  assign w_ones[0]  = 1'b1;
  assign w_zeros[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_ladder
    assign w_ones[i]  = w_ones[i-1] & w_q[i-1];
    assign w_zeros[i] = w_zeros[i-1] & w_qn[i-1];
  end
  assign w_tog = w_up ? w_ones : w_zeros;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_jk[i] = JK_HOLD;
      if (w_ld) begin
        w_jk[i] = w_ldv[i] ? JK_SET : JK_CLEAR;
      end else if (bus.enable && w_tog[i]) begin
        w_jk[i] = JK_TOGGLE;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .J       (w_jk[i][1]),
      .K       (w_jk[i][0]),
      .Q       (w_q[i]),
      .Qnot    (w_qn[i])
    );
  end

  assign bus.count          = w_q;
  assign bus.count_n        = w_qn;
  assign bus.terminal_count = w_tc;
endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: arithmetic reference model, directed cases, random run, cascade.
module tb_jk_sync_counter;
  localparam int W   = 4;
  localparam int MOD = 10;
`ifdef COUNTER_MODULO_EN
  localparam int M = MOD;
`else
  localparam int M = 1 << W;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic rst_c;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;

  always #5 clock = ~clock;

  jk_sync_counter_if #(.WIDTH(W)) ifc ();
  jk_sync_counter_if #(.WIDTH(W)) ifc_lo ();
  jk_sync_counter_if #(.WIDTH(W)) ifc_hi ();

  jk_sync_counter #(.WIDTH(W), .MODULUS(MOD)) dut    (.clock(clock), .reset_n(reset_n), .bus(ifc.slave));
  jk_sync_counter #(.WIDTH(W), .MODULUS(MOD)) dut_lo (.clock(clock), .reset_n(rst_c),   .bus(ifc_lo.slave));
  jk_sync_counter #(.WIDTH(W), .MODULUS(MOD)) dut_hi (.clock(clock), .reset_n(rst_c),   .bus(ifc_hi.slave));

  assign ifc_hi.enable = ifc_lo.terminal_count;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
`ifdef COUNTER_MODULO_EN
    return (v >= MOD) ? MOD - 1 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model_tc(input int c);
    if (!ifc.enable || ifc.load) return 0;
    return (ifc.up_down && c == M - 1) || (!ifc.up_down && c == 0);
  endfunction

  // Reference: count as an integer modulo M.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)        m_cnt <= 0;
    else if (ifc.load)   m_cnt <= clamp(int'(ifc.load_value));
    else if (ifc.enable) m_cnt <= ifc.up_down ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
  end

  always @(negedge clock) begin
    chk("cmp_count",   int'(ifc.count), m_cnt);
    chk("cmp_count_n", int'(ifc.count_n), (~m_cnt) & ((1 << W) - 1));
    chk("cmp_tc",      int'(ifc.terminal_count), model_tc(m_cnt));
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic up, input logic ld, input int lv);
    ifc.enable     = en;
    ifc.up_down    = up;
    ifc.load       = ld;
    ifc.load_value = W'(lv);
  endtask

  initial begin
    reset_n = 1'b0;
    rst_c   = 1'b0;
    drive(1, 1, 0, 0);
    ifc_lo.enable = 1'b1; ifc_lo.up_down = 1'b1; ifc_lo.load = 1'b0; ifc_lo.load_value = '0;
    ifc_hi.up_down = 1'b1; ifc_hi.load = 1'b0; ifc_hi.load_value = '0;

    // Reset held across edges with enable high.
    repeat (3) begin
      tick;
      chk("rst_count", int'(ifc.count), 0);
      chk("rst_count_n", int'(ifc.count_n), 15);
      chk("rst_tc_up", int'(ifc.terminal_count), 0);
    end
    ifc.up_down = 1'b0; #1;
    chk("rst_tc_down", int'(ifc.terminal_count), 1);
    ifc.up_down = 1'b1;
    reset_n = 1'b1;
    repeat (3) tick;
    chk("count_after_reset", int'(ifc.count), 3);
    chk("model_pin_3", m_cnt, 3);

    // Up wrap from 14.
    drive(0, 1, 1, 14); tick;
    drive(1, 1, 0, 0);
`ifndef COUNTER_MODULO_EN
    chk("up_14", int'(ifc.count), 14); chk("up_14_tc", int'(ifc.terminal_count), 0); tick;
    chk("up_15", int'(ifc.count), 15); chk("up_15_tc", int'(ifc.terminal_count), 1); tick;
    chk("up_0",  int'(ifc.count), 0);  chk("up_0_tc",  int'(ifc.terminal_count), 0); tick;
    chk("up_1",  int'(ifc.count), 1);
    chk("model_pin_1", m_cnt, 1);
`else
    repeat (3) tick;
`endif

    // Down wrap from 1.
    drive(0, 0, 1, 1); tick;
    drive(1, 0, 0, 0);
    chk("dn_1", int'(ifc.count), 1); chk("dn_1_tc", int'(ifc.terminal_count), 0); tick;
    chk("dn_0", int'(ifc.count), 0); chk("dn_0_tc", int'(ifc.terminal_count), 1); tick;
`ifndef COUNTER_MODULO_EN
    chk("dn_15", int'(ifc.count), 15); chk("dn_15_tc", int'(ifc.terminal_count), 0); tick;
    chk("dn_14", int'(ifc.count), 14);
`else
    chk("dn_wrap_mod", int'(ifc.count), MOD - 1);
`endif

    // Load beats enable, then hold, then asynchronous reset between edges.
    drive(0, 1, 1, 5); tick;
    chk("pri_5", int'(ifc.count), 5);
    drive(1, 1, 1, 9); tick;
    chk("pri_load_9", int'(ifc.count), 9);
    drive(0, 1, 0, 0);
    repeat (4) begin
      tick;
      chk("hold_9", int'(ifc.count), 9);
      chk("hold_tc", int'(ifc.terminal_count), 0);
    end
    #2 reset_n = 1'b0; #1;
    chk("async_rst_count", int'(ifc.count), 0);
    chk("async_rst_count_n", int'(ifc.count_n), 15);
    tick; reset_n = 1'b1;

`ifdef COUNTER_MODULO_EN
    drive(0, 1, 1, 8); tick;
    drive(1, 1, 0, 0);
    chk("mod_8", int'(ifc.count), 8); tick;
    chk("mod_9", int'(ifc.count), 9); chk("mod_9_tc", int'(ifc.terminal_count), 1); tick;
    chk("mod_0", int'(ifc.count), 0);
    drive(1, 0, 0, 0); tick;
    chk("mod_dn_9", int'(ifc.count), 9);
    drive(0, 1, 1, 13); tick;
    chk("mod_clamp", int'(ifc.count), 9);
`endif

    // Randomized run, checked every cycle by the compare process.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(7) == 0), int'($urandom_range(15)));
      if ($urandom_range(49) == 0) reset_n = 1'b0;
      else                         reset_n = 1'b1;
      tick;
    end
    reset_n = 1'b1;

    // Cascade: upper advances only on the lower's terminal edge.
    tick; rst_c = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk("casc_lo", int'(ifc_lo.count), k % M);
      chk("casc_hi", int'(ifc_hi.count), k / M);
    end
`ifndef COUNTER_MODULO_EN
    chk("casc_lo_final", int'(ifc_lo.count), 4);
    chk("casc_hi_final", int'(ifc_hi.count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
